// File: rtl/jk_bank_driver_pkg.sv
// rtl/jk_bank_driver_pkg.sv - opcodes, FSM encoding and JK excitation helper for jk_bank_driver
package jk_bank_driver_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_INC    = 3'd5;
    localparam logic [2:0] OP_DEC    = 3'd6;
    localparam logic [2:0] OP_CLRERR = 3'd7;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // Returns {j,k} moving one JK flop from cur to nxt on the next capture edge.
    function automatic logic [1:0] excite_bit(input logic cur, input logic nxt,
                                              input logic use_toggle);
        if (cur == nxt)
            return 2'b00;
        else if (nxt)
            return {1'b1, use_toggle};
        else
            return {use_toggle, 1'b1};
    endfunction

endpackage

// File: rtl/jk_bank_driver_excite.sv
// rtl/jk_bank_driver_excite.sv - word-wide combinational J/K excitation from current/next state
module jk_excite
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int USE_TOGGLE = 1
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    localparam logic TGL = (USE_TOGGLE != 0);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign {j[i], k[i]} = excite_bit(cur[i], nxt[i], TGL);
    end

endmodule

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - drives a JK flop bank from word commands and checks its Q feedback
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int USE_TOGGLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] shadow,
    output logic             done,
    output logic             err
);

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_next;
    logic [WIDTH-1:0] ex_j;
    logic [WIDTH-1:0] ex_k;

    assign cmd_ready = (state == ST_IDLE);

    always_comb begin
        target_next = shadow;
        case (cmd_op)
            OP_LOAD:   target_next = cmd_data;
            OP_SET:    target_next = shadow | cmd_data;
            OP_CLEAR:  target_next = shadow & ~cmd_data;
            OP_TOGGLE: target_next = shadow ^ cmd_data;
            OP_INC:    target_next = shadow + WIDTH'(1);
            OP_DEC:    target_next = shadow - WIDTH'(1);
            default:   target_next = shadow;
        endcase
    end

    // Excitation is computed from the pre-handshake shadow so j/k are ready in DRIVE.
    jk_excite #(
        .WIDTH      (WIDTH),
        .USE_TOGGLE (USE_TOGGLE)
    ) u_excite (
        .cur (shadow),
        .nxt (target_next),
        .j   (ex_j),
        .k   (ex_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_INIT;
            j      <= '0;
            k      <= '1;
            shadow <= '0;
            target <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            j    <= '0;
            k    <= '0;
            case (state)
                ST_INIT: state <= ST_IDLE;
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_CLRERR) begin
                            err  <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            target <= target_next;
                            j      <= ex_j;
                            k      <= ex_k;
                            state  <= ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    shadow <= target;
                    state  <= ST_CHECK;
                end
                ST_CHECK: begin
                    // Resync to the real bank so later commands excite from its actual state.
                    if (q_fb != shadow) begin
                        err    <= 1'b1;
                        shadow <= q_fb;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - directed self-checking bench for jk_bank_driver with modelled JK banks
module tb_jk_bank_driver;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_INC    = 3'd5;
    localparam logic [2:0] OP_DEC    = 3'd6;
    localparam logic [2:0] OP_CLRERR = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] stuck;

    logic       cmd_ready1, done1, err1;
    logic [7:0] j1, k1, shadow1, q_fb1;
    logic       cmd_ready0, done0, err0;
    logic [7:0] j0, k0, shadow0, q_fb0;

    logic [7:0] bank1 = 8'($urandom);
    logic [7:0] bank0 = 8'($urandom);

    logic [7:0] jd1, kd1, jd0, kd0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            bank1[i] <= (j1[i] & k1[i]) ? ~bank1[i] : j1[i] ? 1'b1 : k1[i] ? 1'b0 : bank1[i];
            bank0[i] <= (j0[i] & k0[i]) ? ~bank0[i] : j0[i] ? 1'b1 : k0[i] ? 1'b0 : bank0[i];
        end
    end

    assign q_fb1 = bank1 & ~stuck;
    assign q_fb0 = bank0;

    jk_bank_driver #(.WIDTH(8), .USE_TOGGLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .j(j1), .k(k1), .q_fb(q_fb1),
        .shadow(shadow1), .done(done1), .err(err1)
    );

    jk_bank_driver #(.WIDTH(8), .USE_TOGGLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .j(j0), .k(k0), .q_fb(q_fb0),
        .shadow(shadow0), .done(done0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes at the next posedge; returns at the negedge of the done cycle.
    task automatic issue(input logic [2:0] op, input logic [7:0] data);
        check("issue_ready", cmd_ready1, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = $urandom_range(0, 7);
        cmd_data  = 8'($urandom);
        if (op == OP_CLRERR) return;
        jd1 = j1; kd1 = k1; jd0 = j0; kd0 = k0;
        check("drive_no_done", done1, 0);
        @(negedge clk);
        check("check_no_done", done1, 0);
        @(negedge clk);
    endtask

    task automatic expect_done(input string tag, input logic [7:0] sh, input logic er);
        check({tag, "_done"}, done1, 1);
        check({tag, "_ready"}, cmd_ready1, 1);
        check({tag, "_shadow"}, shadow1, sh);
        check({tag, "_qfb"}, q_fb1, sh);
        check({tag, "_err"}, err1, er);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 8'h00; stuck = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_j", j1, 8'h00);
        check("rst_k", k1, 8'hFF);
        check("rst_ready", cmd_ready1, 0);
        check("rst_done", done1, 0);
        check("rst_err", err1, 0);
        check("rst_shadow", shadow1, 8'h00);
        check("rst_bank", q_fb1, 8'h00);

        rst_n = 1'b1;
        #1;
        check("init_j", j1, 8'h00);
        check("init_k", k1, 8'hFF);
        check("init_ready", cmd_ready1, 0);
        @(negedge clk);
        check("idle_ready", cmd_ready1, 1);
        check("idle_j", j1, 8'h00);
        check("idle_k", k1, 8'h00);
        check("idle_qfb", q_fb1, 8'h00);
        check("idle_shadow", shadow1, 8'h00);

        issue(OP_LOAD, 8'hA5);
        check("load_j_tgl", jd1, 8'hA5);
        check("load_k_tgl", kd1, 8'hA5);
        check("load_j_jk", jd0, 8'hA5);
        check("load_k_jk", kd0, 8'h00);
        expect_done("load", 8'hA5, 0);
        check("load_shadow_jk", shadow0, 8'hA5);
        check("load_qfb_jk", q_fb0, 8'hA5);

        issue(OP_SET, 8'h0F);
        expect_done("set", 8'hAF, 0);
        issue(OP_CLEAR, 8'hF0);
        expect_done("clear", 8'h0F, 0);
        issue(OP_TOGGLE, 8'hFF);
        expect_done("toggle", 8'hF0, 0);

        issue(OP_LOAD, 8'hFF);
        expect_done("load_ff", 8'hFF, 0);
        issue(OP_INC, 8'h5A);
        check("inc_j", jd1, 8'hFF);
        check("inc_k", kd1, 8'hFF);
        expect_done("inc_wrap", 8'h00, 0);
        issue(OP_DEC, 8'h12);
        check("dec_j", jd1, 8'hFF);
        expect_done("dec_wrap", 8'hFF, 0);

        issue(OP_LOAD, 8'h00);
        expect_done("load_00", 8'h00, 0);
        stuck = 8'h08;
        issue(OP_LOAD, 8'hFF);
        expect_done("stuck", 8'hF7, 1);
        issue(OP_CLRERR, 8'hFF);
        check("clrerr_done", done1, 1);
        check("clrerr_err", err1, 0);
        check("clrerr_ready", cmd_ready1, 1);
        check("clrerr_shadow", shadow1, 8'hF7);

        // Bank really holds 0xFF, so a NOP readback exposes the stale shadow.
        stuck = 8'h00;
        issue(OP_NOP, 8'h33);
        check("nop_j", jd1, 8'h00);
        check("nop_k", kd1, 8'h00);
        expect_done("nop_resync", 8'hFF, 1);
        issue(OP_CLRERR, 8'h00);
        check("clrerr2_err", err1, 0);

        check("abort_ready", cmd_ready1, 1);
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 8'h3C;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_drive_j", j1, 8'hC3);
        check("abort_drive_k", k1, 8'hC3);
        rst_n = 1'b0;
        #1;
        check("abort_j", j1, 8'h00);
        check("abort_k", k1, 8'hFF);
        check("abort_shadow", shadow1, 8'h00);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("abort_no_done", done1, 0);
        end
        rst_n = 1'b1;
        #1;
        check("abort_init_ready", cmd_ready1, 0);
        check("abort_init_k", k1, 8'hFF);
        @(negedge clk);
        check("abort_idle_ready", cmd_ready1, 1);
        check("abort_idle_done", done1, 0);
        check("abort_qfb", q_fb1, 8'h00);
        check("abort_shadow2", shadow1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Drives a bank of WIDTH external JK flip-flops (no reset, JK posedge-capture) by generating per-bit J/K excitation from word-level commands.
- Keeps a shadow copy of the bank state and checks the bank's Q feedback one cycle after each drive.
- Sits between a command source (valid/ready) and the JK flop array, so callers never compute J/K by hand.

Parameters:
- WIDTH, 8, number of JK flops driven; 1..32.
- USE_TOGGLE, 1, if 1 a changing bit is driven J=K=1; if 0 a 0->1 change is J=1,K=0 and a 1->0 change is J=0,K=1.

Ports:
- clk  input  1  rising-edge clock, shared with the flop bank.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in state IDLE.
- cmd_op  input  3  opcode: 0 NOP, 1 LOAD, 2 SET, 3 CLEAR, 4 TOGGLE, 5 INC, 6 DEC, 7 CLRERR.
- cmd_data  input  WIDTH  load value or bit mask; ignored for NOP, INC, DEC and CLRERR.
- j  output  WIDTH  J inputs of the flop bank; registered.
- k  output  WIDTH  K inputs of the flop bank; registered.
- q_fb  input  WIDTH  Q outputs of the flop bank.
- shadow  output  WIDTH  believed bank state; registered.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  sticky mismatch flag.

Behaviour:
- Reset (rst_n low, async):
  - state=INIT, j=0, k=all-ones (the bank clears on any clock edges during reset).
  - shadow=0, done=0, err=0, cmd_ready=0.
- INIT: one cycle after rst_n rises, j=0 and k=all-ones are held; next state IDLE.
- Outside INIT and DRIVE, j=k=0, so the bank holds.
- IDLE: cmd_ready=1. Handshake when cmd_valid and cmd_ready are both high at a rising edge (cycle T):
  - target is registered: LOAD=data, SET=shadow|data, CLEAR=shadow&~data, TOGGLE=shadow^data, INC=shadow+1, DEC=shadow-1, NOP=shadow.
  - INC and DEC wrap modulo 2^WIDTH.
  - CLRERR: err<=0 at that edge, done pulses in T+1, and the FSM stays in IDLE; no drive occurs.
  - Any other opcode: next state DRIVE.
- DRIVE (cycle T+1), per bit i:
  - target==shadow: j=0, k=0.
  - 0->1: j=1, k=USE_TOGGLE.
  - 1->0: j=USE_TOGGLE, k=1.
  - The bank captures at the edge ending T+1. At that edge shadow<=target and the next state is CHECK.
- CHECK (cycle T+2): compare q_fb to shadow.
  - On mismatch: err<=1 and shadow<=q_fb (resync to the real bank).
  - done<=1, next state IDLE.
  - done is high for exactly cycle T+3, with cmd_ready=1 in that same cycle.
- Throughput: one command per 3 cycles; CLRERR takes 1 cycle.
- cmd_valid is ignored outside IDLE; cmd_op and cmd_data are only sampled at the handshake edge.
- err and done update on the same edge. The err bit seen in the done cycle reflects that command's check.
- NOP still runs DRIVE and CHECK with all bits held, so it acts as a readback check.
- Reset mid-command aborts immediately. The command is lost and does not produce done; the bank is cleared via the reset and INIT values.

Decomposition:
- Shared package holds:
  - the opcode constants OP_NOP..OP_CLRERR;
  - the FSM state encoding INIT/IDLE/DRIVE/CHECK (2 bits);
  - the per-bit excitation function (current, next, use_toggle) -> {j,k}.
- One natural sub-module: jk_excite, combinational, WIDTH-wide, mapping shadow/target to j/k; instanced once in the driver.
- The bench instantiates WIDTH existing JK flops as the bank.

Test Plan:
- Reset then release with the bank at random power-up Q: j=0/k=all-ones during reset and the INIT cycle, then q_fb=0x00, shadow=0x00, cmd_ready=1.
- LOAD 0xA5 from 0x00 with USE_TOGGLE=1: in DRIVE j=0xA5, k=0xA5; done at T+3; q_fb=0xA5; err=0.
- Repeat with USE_TOGGLE=0: j=0xA5, k=0x00.
- From 0xA5, issue SET 0x0F, then CLEAR 0xF0, then TOGGLE 0xFF: shadow and q_fb become 0xAF, then 0x0F, then 0xF0.
- INC from 0xFF: shadow wraps to 0x00; with USE_TOGGLE=1, DRIVE j=k=0xFF. DEC from 0x00 gives 0xFF.
- Force q_fb bit 3 stuck at 0 and LOAD 0xFF: err=1 at the done cycle and shadow=0xF7. A following CLRERR gives err=0 and done one cycle after the handshake.
- Assert rst_n low during DRIVE of a LOAD 0x3C: no done pulse; after release, shadow=0x00, q_fb=0x00, and the FSM returns to IDLE after one INIT cycle.
